// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - one-hot state encoding shared by the Booth multiplier files
package mult_pkg;

    localparam int STATE_W = 6;

    localparam logic [STATE_W-1:0] S_IDLE  = 6'b000001;
    localparam logic [STATE_W-1:0] S_TEST  = 6'b000010;
    localparam logic [STATE_W-1:0] S_ADD   = 6'b000100;
    localparam logic [STATE_W-1:0] S_SUB   = 6'b001000;
    localparam logic [STATE_W-1:0] S_SHIFT = 6'b010000;
    localparam logic [STATE_W-1:0] S_DONE  = 6'b100000;

endpackage

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - M/A/Q/Q_1/cnt registers with add, subtract and arithmetic shift
module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_add,
    input  logic                 i_sub,
    input  logic                 i_shift,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_q0,
    output logic                 o_q_1,
    output logic                 o_cnt_last,
    output logic [2*WIDTH-1:0]   o_product
);

    // One extra bit lets unsigned all-ones operands stay positive in Booth form
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  r_m;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_q;
    logic          r_q_1;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_m_ext;
    logic [N-1:0]  w_q_ext;

    assign w_m_ext = {i_signed & i_multiplicand[WIDTH-1], i_multiplicand};
    assign w_q_ext = {i_signed & i_multiplier[WIDTH-1], i_multiplier};

    // Operand load, accumulate, and the shift of {A,Q,Q_1} with A's sign replicated
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m   <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_q_1 <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_m   <= w_m_ext;
            r_a   <= '0;
            r_q   <= w_q_ext;
            r_q_1 <= 1'b0;
            r_cnt <= CW'(N);
        end else if (i_add) begin
            r_a <= r_a + r_m;
        end else if (i_sub) begin
            r_a <= r_a - r_m;
        end else if (i_shift) begin
            {r_a, r_q, r_q_1} <= {r_a[N-1], r_a, r_q};
            r_cnt             <= r_cnt - CW'(1);
        end
    end

    assign o_q0       = r_q[0];
    assign o_q_1      = r_q_1;
    assign o_cnt_last = (r_cnt == CW'(1));
    // Low 2*WIDTH bits of {A,Q} as they will be after the pending shift
    assign o_product  = {r_a[WIDTH-1:0], r_q[N-1:1]};

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier with Start/Busy/Done handshake
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_add,
    output logic                 o_sub,
    output logic                 o_shift
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_q0;
    logic               w_q_1;
    logic               w_cnt_last;
    logic [2*WIDTH-1:0] w_product;

    booth_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load         (w_load),
        .i_add          (o_add),
        .i_sub          (o_sub),
        .i_shift        (o_shift),
        .i_signed       (i_signed),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_q0           (w_q0),
        .o_q_1          (w_q_1),
        .o_cnt_last     (w_cnt_last),
        .o_product      (w_product)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: Booth recoding of {Q[0],Q_1} picks add, subtract or plain shift
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_TEST;
            S_TEST: begin
                case ({w_q0, w_q_1})
                    2'b10:   w_next = S_SUB;
                    2'b01:   w_next = S_ADD;
                    default: w_next = S_SHIFT;
                endcase
            end
            S_ADD:   w_next = S_SHIFT;
            S_SUB:   w_next = S_SHIFT;
            S_SHIFT: w_next = w_cnt_last ? S_DONE : S_TEST;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore status outputs and the operand-load strobe
    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_done  = (r_state == S_DONE);
        o_add   = (r_state == S_ADD);
        o_sub   = (r_state == S_SUB);
        o_shift = (r_state == S_SHIFT);
        w_load  = (r_state == S_IDLE) && i_start;
    end

    // Product captured on the final shift so it is already valid while Done is high
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_product <= '0;
        end else if ((r_state == S_SHIFT) && w_cnt_last) begin
            r_product <= w_product;
        end
    end

    assign o_product = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          lat;
        int          adds;
        int          subs;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          adds;
        int          subs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        add;
    logic        sub;
    logic        shift;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   ec     = 0;
    exp_t sb[$];
    vec_t vt[9];

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_signed       (sgn),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product),
        .o_add          (add),
        .o_sub          (sub),
        .o_shift        (shift)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        ec++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int sa, sbv;
        logic [8:0] q;
        logic prev;
        sa  = s ? int'($signed(a)) : int'(a);
        sbv = s ? int'($signed(b)) : int'(b);
        e.prod = 16'(sa * sbv);
        q = {s & b[7], b};
        prev = 1'b0;
        e.adds = 0;
        e.subs = 0;
        for (int i = 0; i < 9; i++) begin
            if (q[i] && !prev) e.subs++;
            if (!q[i] && prev) e.adds++;
            prev = q[i];
        end
        e.lat = 19 + e.adds + e.subs;
        return e;
    endfunction

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.prod = v.prod;
        e.lat  = v.lat;
        e.adds = v.adds;
        e.subs = v.subs;
        return e;
    endfunction

    // Monitor: latency, add/sub occupancy, Done width, scoreboard compare
    initial begin
        int   t0 = 0;
        int   n_add = 0;
        int   n_sub = 0;
        logic prev_busy = 1'b0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    t0 = ec;
                    n_add = 0;
                    n_sub = 0;
                end
                if (add) n_add++;
                if (sub) n_sub++;
                if (prev_done) check("done_width", 32'(done), 32'd0);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("product", 32'(product), 32'(e.prod));
                        check("latency", 32'(ec - t0 + 1), 32'(e.lat));
                        check("add_cycles", 32'(n_add), 32'(e.adds));
                        check("sub_cycles", 32'(n_sub), 32'(e.subs));
                    end
                end
                prev_busy = busy;
                prev_done = done;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        wait_idle();
        start  = 1'b1;
        sgn    = s;
        mcand  = a;
        mplier = b;
        sb.push_back(e);
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        start  = 1'b0;
        sgn    = 1'($urandom);
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
        wait_drain();
    endtask

    initial begin
        vt[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 21, 1, 1};
        vt[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 20, 0, 1};
        vt[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 20, 0, 1};
        vt[3] = '{1'b1, 8'h03, 8'hFF, 16'hFFFD, 20, 0, 1};
        vt[4] = '{1'b0, 8'hAB, 8'h00, 16'h0000, 19, 0, 0};
        vt[5] = '{1'b0, 8'h05, 8'h06, 16'h001E, 21, 1, 1};
        vt[6] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 20, 0, 1};
        vt[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 21, 1, 1};
        vt[8] = '{1'b0, 8'h55, 8'hAA, 16'h3872, 27, 4, 4};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; mcand = 8'h00; mplier = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_status", 32'({add, sub, shift}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_op(vt[i].sgn, vt[i].a, vt[i].b, from_vec(vt[i]));

        for (int i = 0; i < 16; i++) begin
            logic       s;
            logic [7:0] a, b;
            s = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(s, a, b, model(s, a, b));
        end

        // Start held high: back-to-back operations, operands rewritten while busy
        wait_idle();
        start  = 1'b1;
        sgn    = vt[0].sgn; mcand = vt[0].a; mplier = vt[0].b;
        sb.push_back(from_vec(vt[0]));
        for (int k = 1; k < 5; k++) begin
            int n = 0;
            while (!busy && n < 60) begin @(negedge clk); n++; end
            sgn = vt[k].sgn; mcand = vt[k].a; mplier = vt[k].b;
            sb.push_back(from_vec(vt[k]));
            n = 0;
            while (busy && n < 60) begin @(negedge clk); n++; end
            if (n >= 60) check("b2b_timeout", 32'd1, 32'd0);
        end
        begin
            int n = 0;
            while (!busy && n < 60) begin @(negedge clk); n++; end
        end
        start  = 1'b0;
        mcand  = 8'h3C;
        mplier = 8'hC3;
        wait_drain();

        // Asynchronous reset while in ADD: abort, clear, no Done
        wait_idle();
        start = 1'b1; sgn = 1'b0; mcand = 8'h05; mplier = 8'h06;
        sb.push_back(from_vec(vt[5]));
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!add && n < 60) begin @(negedge clk); n++; end
            check("reached_add", 32'(add), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_status", 32'({done, add, sub, shift}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);
        do_op(1'b0, 8'h05, 8'h06, from_vec(vt[5]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
